// File: rtl/sb_tx_scheduler.sv
// sb_tx_scheduler: round-robin arbiter feeding one sideband serializer,
// holding each packet until accepted and enforcing an idle gap after it.
// Ports: clk/rst (async, active-high); enable gates new grants;
//   req_valid/req_data/req_ready: per-source packets and one-hot accept;
//   ser_data/ser_valid/ser_ready/ser_done: serializer side;
//   grant_id: owner of current/last packet; busy: not idle.
module sb_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 128,
    parameter int GAP_CYCLES = 32,
    parameter int GAP_W      = $clog2(GAP_CYCLES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           ser_data,
    output logic                       ser_valid,
    input  logic                       ser_ready,
    input  logic                       ser_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);
    // GAP_W collapses to 0 when GAP_CYCLES=0; keep a 1-bit counter then.
    localparam int CW  = (GAP_W < 1) ? 1 : GAP_W;
    localparam logic [CW-1:0] GAP_LOAD =
        CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr, rr_ptr_d;
    logic [IDW-1:0]   gid_d;
    logic [WIDTH-1:0] data_d;
    logic [CW-1:0]    gap_cnt, gap_d;

    logic [2*NUM_REQ-1:0] rot;
    logic [IDW:0]         sum;
    logic [IDW-1:0]       win_idx;
    logic                 win_found;
    logic [WIDTH-1:0]     win_data;
    logic                 grant;
    logic                 pkt_end;

    // Rotating the doubled vector puts rr_ptr at bit 0, so the lowest set
    // bit of rot is the round-robin winner's offset from rr_ptr.
    assign rot = {req_valid, req_valid} >> rr_ptr;

    always_comb begin
        win_found = 1'b0;
        sum       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                win_found = 1'b1;
                sum       = {1'b0, rr_ptr} + (IDW+1)'(k);
            end
        end
        if (sum >= (IDW+1)'(NUM_REQ))
            sum = sum - (IDW+1)'(NUM_REQ);
        win_idx = sum[IDW-1:0];
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == IDW'(k))
                win_data = req_data[k*WIDTH +: WIDTH];
        end
    end

    assign grant = (state_q == IDLE) && enable && win_found;

    always_comb begin
        req_ready = '0;
        if (grant)
            req_ready[win_idx] = 1'b1;
    end

    // Last bit shifted: either during the handshake cycle or afterwards.
    assign pkt_end = ser_done &&
                     ((state_q == WAIT_DONE) ||
                      (state_q == SEND && ser_ready));

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr;
        gid_d    = grant_id;
        data_d   = ser_data;
        gap_d    = gap_cnt;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    data_d   = win_data;
                    gid_d    = win_idx;
                    rr_ptr_d = (win_idx == IDW'(NUM_REQ - 1)) ?
                               '0 : win_idx + 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (ser_ready)
                    state_d = WAIT_DONE;
            end
            WAIT_DONE: ;
            GAP: begin
                if (gap_cnt == '0)
                    state_d = IDLE;
                else
                    gap_d = gap_cnt - 1'b1;
            end
        endcase
        if (pkt_end) begin
            if (GAP_CYCLES == 0) begin
                state_d = IDLE;
            end else begin
                state_d = GAP;
                gap_d   = GAP_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr   <= '0;
            ser_data <= '0;
            grant_id <= '0;
            gap_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr   <= rr_ptr_d;
            ser_data <= data_d;
            grant_id <= gid_d;
            gap_cnt  <= gap_d;
        end
    end

    assign ser_valid = (state_q == SEND);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sb_tx_scheduler.sv
// tb_sb_tx_scheduler: directed bench for sb_tx_scheduler using three
// instances (GAP_CYCLES 32, 4 and 0) sharing one set of inputs.
module tb_sb_tx_scheduler;

    localparam int N = 4;
    localparam int W = 128;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic           ser_ready;
    logic           ser_done;

    logic [N-1:0] rdy_a, rdy_b, rdy_z;
    logic [W-1:0] dat_a, dat_b, dat_z;
    logic         val_a, val_b, val_z;
    logic [1:0]   gid_a, gid_b, gid_z;
    logic         bsy_a, bsy_b, bsy_z;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sb_tx_scheduler #(.NUM_REQ(N), .WIDTH(W), .GAP_CYCLES(32)) u_a (
        .clk(clk), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(rdy_a),
        .ser_data(dat_a), .ser_valid(val_a), .ser_ready(ser_ready),
        .ser_done(ser_done), .grant_id(gid_a), .busy(bsy_a)
    );

    sb_tx_scheduler #(.NUM_REQ(N), .WIDTH(W), .GAP_CYCLES(4)) u_b (
        .clk(clk), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(rdy_b),
        .ser_data(dat_b), .ser_valid(val_b), .ser_ready(ser_ready),
        .ser_done(ser_done), .grant_id(gid_b), .busy(bsy_b)
    );

    sb_tx_scheduler #(.NUM_REQ(N), .WIDTH(W), .GAP_CYCLES(0)) u_z (
        .clk(clk), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(rdy_z),
        .ser_data(dat_z), .ser_valid(val_z), .ser_ready(ser_ready),
        .ser_done(ser_done), .grant_id(gid_z), .busy(bsy_z)
    );

    task automatic check(input string tag,
                         input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        enable    = 1'b1;
        req_valid = '0;
        ser_ready = 1'b0;
        ser_done  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic pulse_done();
        ser_done = 1'b1;
        tick();
        ser_done = 1'b0;
        #1;
    endtask

    logic [W-1:0] pat_a5, pat0, pat1;
    int c, w, bad;

    initial begin
        pat_a5 = {16{8'hA5}};
        pat0   = {4{32'h0123_4567}};
        pat1   = {4{32'hDEAD_BEEF}};
        for (int i = 0; i < N; i++)
            req_data[i*W +: W] = {4{32'h1000_0000 + 32'(i)}};

        // reset values
        do_reset();
        check("rst_busy", bsy_a, 0);
        check("rst_valid", val_a, 0);
        check("rst_gid", gid_a, 0);
        check("rst_data", dat_a, 0);
        check("rst_ready", rdy_a, 0);

        // single requester 2, GAP 32
        req_data[2*W +: W] = pat_a5;
        req_valid = 4'b0100;
        ser_ready = 1'b1;
        #1;
        check("t1_ready", rdy_a, 4'b0100);
        tick();
        req_valid = '0;
        #1;
        check("t1_valid", val_a, 1);
        check("t1_data", dat_a, pat_a5);
        check("t1_gid", gid_a, 2);
        check("t1_ready_off", rdy_a, 0);
        tick();
        check("t1_valid_1cyc", val_a, 0);
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (val_a !== 1'b0 || bsy_a !== 1'b1) bad++;
            tick();
        end
        check("t1_waitdone", bad, 0);
        pulse_done();
        c = 0;
        while (bsy_a && c < 100) begin
            tick();
            c++;
        end
        check("t1_gap32", c, 32);

        // round robin, all valid, GAP 4
        do_reset();
        req_valid = 4'b1111;
        ser_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            w = 0;
            while (rdy_b == '0 && w < 50) begin
                tick();
                w++;
            end
            check("rr_ready", rdy_b, 4'b0001 << (g % 4));
            if (g > 0)
                check("rr_spacing", w + 1, 5);
            tick();
            check("rr_gid", gid_b, g % 4);
            tick();
            pulse_done();
        end

        // serializer stall for 10 cycles
        do_reset();
        req_data[0 +: W] = pat0;
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = 4'b1111;
        #1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (val_b !== 1'b1 || dat_b !== pat0 || rdy_b !== '0) bad++;
            tick();
        end
        check("stall_stable", bad, 0);
        ser_ready = 1'b1;
        tick();
        check("stall_accept", val_b, 0);
        check("stall_busy", bsy_b, 1);

        // ready and done together, GAP 0
        do_reset();
        req_data[W +: W] = pat1;
        req_valid = 4'b0010;
        ser_ready = 1'b1;
        #1;
        tick();
        check("z_gid1", gid_z, 1);
        check("z_data", dat_z, pat1);
        req_valid = 4'b1000;
        ser_done  = 1'b1;
        tick();
        ser_done = 1'b0;
        #1;
        check("z_idle", bsy_z, 0);
        check("z_next_ready", rdy_z, 4'b1000);
        tick();
        check("z_gid3", gid_z, 3);
        check("z_valid", val_z, 1);
        req_valid = 4'b1001;
        tick();
        pulse_done();
        check("z_wrap_ready", rdy_z, 4'b0001);

        // enable low holds off grants and keeps rr_ptr
        do_reset();
        enable    = 1'b0;
        req_valid = 4'b0110;
        ser_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (rdy_b !== '0 || bsy_b !== 1'b0) bad++;
            tick();
        end
        check("en_hold", bad, 0);
        enable = 1'b1;
        #1;
        check("en_ready", rdy_b, 4'b0010);
        tick();
        check("en_gid", gid_b, 1);
        tick();
        enable = 1'b0;
        pulse_done();
        for (int i = 0; i < 6; i++)
            tick();
        req_valid = 4'b0011;
        #1;
        check("en_off_ready", rdy_b, 0);
        check("en_off_busy", bsy_b, 0);
        enable = 1'b1;
        #1;
        check("en_wrap_ready", rdy_b, 4'b0001);

        // reset in WAIT_DONE
        do_reset();
        req_valid = 4'b0100;
        ser_ready = 1'b1;
        #1;
        tick();
        req_valid = '0;
        tick();
        check("mid_busy", bsy_b, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", bsy_b, 0);
        check("mid_rst_valid", val_b, 0);
        check("mid_rst_gid", gid_b, 0);
        check("mid_rst_data", dat_b, 0);
        check("mid_rst_ready", rdy_b, 0);
        tick();
        rst = 1'b0;
        req_valid = 4'b1001;
        #1;
        check("mid_ptr0", rdy_b, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
